writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 88 ++++++++
 tb/tb_writeback_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback pipeline register: selects the result, registers it and drives the register-file write port.
// Also provides a sticky halt flag and a retired-instruction counter.
module writeback_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_reg_write,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     mem_pc_plus2,
  input  logic [DATA_W-1:0]     mem_imm,
  input  logic                  mem_halt,
  output logic [REG_ADDR_W-1:0] DstReg,
  output logic [DATA_W-1:0]     DstData,
  output logic                  WriteReg,
  output logic                  wb_valid,
  output logic                  halted,
  output logic [15:0]           retired_count
);

  logic                  validQ;
  logic [REG_ADDR_W-1:0] dstQ;
  logic                  regWriteQ;
  logic                  haltQ;
  logic [DATA_W-1:0]     dataQ;
  logic                  haltedQ;
  logic [15:0]           retiredQ;

  logic [DATA_W-1:0]     wbDataD;
  logic                  haltedD;
  logic                  retireNow;

  always_comb begin
    wbDataD = mem_alu_result;
    unique case (mem_wb_sel)
      2'b00:   wbDataD = mem_alu_result;
      2'b01:   wbDataD = mem_rdata;
      2'b10:   wbDataD = mem_pc_plus2;
      default: wbDataD = mem_imm;
    endcase
  end

  // The instruction trailing HLT is already squashed at the edge where the halt flag is set.
  assign haltedD   = haltedQ | (validQ & haltQ);
  // An instruction retires when it leaves the stage: not held by a stall, or discarded by flush.
  assign retireNow = validQ & (~stall | flush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      validQ    <= 1'b0;
      dstQ      <= '0;
      regWriteQ <= 1'b0;
      haltQ     <= 1'b0;
      dataQ     <= '0;
      haltedQ   <= 1'b0;
      retiredQ  <= '0;
    end else begin
      haltedQ <= haltedD;
      if (retireNow) begin
        retiredQ <= retiredQ + 16'd1;
      end
      if (flush) begin
        validQ <= 1'b0;
      end else if (!stall) begin
        validQ    <= mem_valid & ~haltedD;
        dstQ      <= mem_dst;
        regWriteQ <= mem_reg_write;
        haltQ     <= mem_halt;
        dataQ     <= wbDataD;
      end
    end
  end

  assign DstReg        = dstQ;
  assign DstData       = dataQ;
  assign WriteReg      = validQ & regWriteQ & ~haltQ & (dstQ != '0);
  assign wb_valid      = validQ;
  assign halted        = haltedQ;
  assign retired_count = retiredQ;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage; expected values are hand-computed constants.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [3:0]  mem_dst;
  logic        mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_result;
  logic [15:0] mem_rdata;
  logic [15:0] mem_pc_plus2;
  logic [15:0] mem_imm;
  logic        mem_halt;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        WriteReg;
  logic        wb_valid;
  logic        halted;
  logic [15:0] retired_count;

  int vectors;
  int miscompares;

  writeback_stage #(
    .DATA_W     (16),
    .REG_ADDR_W (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_dst        (mem_dst),
    .mem_reg_write  (mem_reg_write),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_pc_plus2   (mem_pc_plus2),
    .mem_imm        (mem_imm),
    .mem_halt       (mem_halt),
    .DstReg         (DstReg),
    .DstData        (DstData),
    .WriteReg       (WriteReg),
    .wb_valid       (wb_valid),
    .halted         (halted),
    .retired_count  (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWb(input string tag, input logic [3:0] dst, input logic [15:0] data,
                         input logic we, input logic vld, input logic hlt, input logic [15:0] cnt);
    checkVal({tag, ".DstReg"},        {28'd0, DstReg},        {28'd0, dst});
    checkVal({tag, ".DstData"},       {16'd0, DstData},       {16'd0, data});
    checkVal({tag, ".WriteReg"},      {31'd0, WriteReg},      {31'd0, we});
    checkVal({tag, ".wb_valid"},      {31'd0, wb_valid},      {31'd0, vld});
    checkVal({tag, ".halted"},        {31'd0, halted},        {31'd0, hlt});
    checkVal({tag, ".retired_count"}, {16'd0, retired_count}, {16'd0, cnt});
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    mem_valid      = 1'b0;
    mem_dst        = 4'd0;
    mem_reg_write  = 1'b0;
    mem_wb_sel     = 2'b00;
    mem_alu_result = 16'h0000;
    mem_rdata      = 16'h1234;
    mem_pc_plus2   = 16'h0042;
    mem_imm        = 16'hAB00;
    mem_halt       = 1'b0;

    #2;
    tick();
    checkWb("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);

    // Basic ALU write to R2
    rst            = 1'b1;
    mem_valid      = 1'b1;
    mem_dst        = 4'd2;
    mem_reg_write  = 1'b1;
    mem_alu_result = 16'h000F;
    tick();
    checkWb("alu", 4'd2, 16'h000F, 1'b1, 1'b1, 1'b0, 16'd0);

    // Source select sweep; previous instruction retires each edge
    mem_wb_sel = 2'b01;
    tick();
    checkWb("sel01", 4'd2, 16'h1234, 1'b1, 1'b1, 1'b0, 16'd1);
    mem_wb_sel = 2'b10;
    tick();
    checkWb("sel10", 4'd2, 16'h0042, 1'b1, 1'b1, 1'b0, 16'd2);
    mem_wb_sel = 2'b11;
    tick();
    checkWb("sel11", 4'd2, 16'hAB00, 1'b1, 1'b1, 1'b0, 16'd3);

    // Write to R0 is suppressed but still retires
    mem_wb_sel     = 2'b00;
    mem_dst        = 4'd0;
    mem_alu_result = 16'hFFFF;
    tick();
    checkWb("r0", 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'd4);
    mem_dst        = 4'd5;
    mem_alu_result = 16'h0055;
    tick();
    checkWb("r5", 4'd5, 16'h0055, 1'b1, 1'b1, 1'b0, 16'd5);

    // Stall for three edges: everything holds, no count
    stall          = 1'b1;
    mem_dst        = 4'd7;
    mem_alu_result = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkWb("stall", 4'd5, 16'h0055, 1'b1, 1'b1, 1'b0, 16'd5);
    end

    // Flush overrides stall; stalled instruction is counted as it leaves
    flush = 1'b1;
    tick();
    checkVal("flush.wb_valid",      {31'd0, wb_valid},      32'd0);
    checkVal("flush.WriteReg",      {31'd0, WriteReg},      32'd0);
    checkVal("flush.retired_count", {16'd0, retired_count}, 32'd6);

    // HLT then further valid writes
    flush    = 1'b0;
    stall    = 1'b0;
    mem_dst  = 4'd3;
    mem_halt = 1'b1;
    tick();
    checkWb("hlt", 4'd3, 16'h7777, 1'b0, 1'b1, 1'b0, 16'd6);
    mem_halt       = 1'b0;
    mem_dst        = 4'd4;
    mem_alu_result = 16'h4444;
    tick();
    checkVal("halt1.halted",        {31'd0, halted},        32'd1);
    checkVal("halt1.WriteReg",      {31'd0, WriteReg},      32'd0);
    checkVal("halt1.wb_valid",      {31'd0, wb_valid},      32'd0);
    checkVal("halt1.retired_count", {16'd0, retired_count}, 32'd7);
    tick();
    checkVal("halt2.halted",        {31'd0, halted},        32'd1);
    checkVal("halt2.WriteReg",      {31'd0, WriteReg},      32'd0);
    checkVal("halt2.retired_count", {16'd0, retired_count}, 32'd7);

    // Reset mid-operation with stall asserted clears everything
    stall = 1'b1;
    rst   = 1'b0;
    tick();
    checkWb("rst2", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);

    // In-flight instruction discarded by reset: no write, no count
    rst   = 1'b1;
    stall = 1'b0;
    tick();
    checkWb("refill", 4'd4, 16'h4444, 1'b1, 1'b1, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    checkWb("rst3", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0);

    // Counter wrap: first edge captures, each later edge retires one
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
    end
    #1;
    checkVal("wrap.ffff", {16'd0, retired_count}, 32'h0000FFFF);
    tick();
    checkVal("wrap.zero", {16'd0, retired_count}, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
